product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 119 +++++++++++
 tb/tb_product_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
//
// Purpose:
//   Sums N_TERMS unsigned products from the upstream 2x3-bit multiplier stage
//   into a saturating ACC_W-bit accumulator. When the sum is complete, the
//   block holds the result with a valid/ready handshake until downstream
//   consumes it, and then starts a fresh sum.
//
// Parameters:
//   N_TERMS : number of products summed per result (2..255)
//   ACC_W   : accumulator and result width (5..16)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   clear      in   synchronous discard of the partial or pending result
//   in_valid   in   in_product is valid this cycle
//   in_ready   out  block accepts a product this cycle (ACCUM state)
//   in_product in   [4:0] unsigned product, normally 0..21
//   out_valid  out  acc_out/out_ovf hold a completed sum (HOLD state)
//   out_ready  in   downstream consumes the result this cycle
//   acc_out    out  [ACC_W-1:0] saturated sum
//   out_ovf    out  saturation occurred during the current sum (sticky)
//   term_count out  [7:0] products accepted into the current sum

module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_ovf,
    output logic [7:0]       term_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
    localparam logic [7:0]       TERMS_LST = 8'(N_TERMS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       count_q, count_d;

    // One extra bit of headroom is enough: ACC_W >= 5, so the largest
    // accumulator value plus the largest 5-bit product still fits.
    logic [ACC_W:0]   sum_wide;
    logic [7:0]       count_inc;

    assign sum_wide  = {1'b0, acc_q} + {{(ACC_W - 4){1'b0}}, in_product};
    assign count_inc = count_q + 8'd1;

    // Next-state logic. Priority is clear, then the result handshake, then
    // product acceptance; reset is handled in the register process.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);

        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if (state_q == HOLD) begin
            if (out_ready) begin
                state_d = ACCUM;
                acc_d   = '0;
                ovf_d   = 1'b0;
                count_d = '0;
            end
        end else if (in_valid) begin
            // The top bit of the widened sum marks a result past ACC_MAX.
            if (sum_wide[ACC_W]) begin
                acc_d = ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_wide[ACC_W-1:0];
            end
            count_d = count_inc;
            if (count_inc == TERMS_LST) begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign acc_out    = acc_q;
    assign out_ovf    = ovf_q;
    assign term_count = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//
// Two instances share all inputs: dut7 (ACC_W=7) and dut6 (ACC_W=6), both
// with N_TERMS=4. The narrower one exposes saturation on the same traffic.

module tb_product_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [4:0] in_product;
    logic       out_ready;

    logic       in_ready7, out_valid7, ovf7;
    logic [6:0] acc7;
    logic [7:0] count7;
    logic       in_ready6, out_valid6, ovf6;
    logic [5:0] acc6;
    logic [7:0] count6;

    int vectors;
    int miscompares;

    product_accumulator #(.N_TERMS(4), .ACC_W(7)) dut7 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready7), .in_product(in_product),
        .out_valid(out_valid7), .out_ready(out_ready),
        .acc_out(acc7), .out_ovf(ovf7), .term_count(count7)
    );

    product_accumulator #(.N_TERMS(4), .ACC_W(6)) dut6 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready6), .in_product(in_product),
        .out_valid(out_valid6), .out_ready(out_ready),
        .acc_out(acc6), .out_ovf(ovf6), .term_count(count6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs set before step() are sampled at the next rising edge; outputs
    // are looked at 1ns after that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_product = 5'd0; out_ready = 1'b0;
    endtask

    task automatic push(input logic [4:0] p);
        in_valid = 1'b1; in_product = p;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        in_valid = 1'b1; in_product = 5'd9;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        vectors++;
        if (in_ready7 !== 1'b1 || out_valid7 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hs: got in_ready=%b out_valid=%b expected 1/0", in_ready7, out_valid7);
        end
        vectors++;
        if (acc7 !== 7'd0 || ovf7 !== 1'b0 || count7 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got acc=%0d ovf=%b cnt=%0d expected 0/0/0", acc7, ovf7, count7);
        end
    endtask

    task automatic test_full_sum();
        push(5'd21); push(5'd21); push(5'd21);
        vectors++;
        if (out_valid7 !== 1'b0 || count7 !== 8'd3 || acc6 !== 6'd63 || ovf6 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_third: got ov=%b cnt=%0d acc6=%0d ovf6=%b expected 0/3/63/0", out_valid7, count7, acc6, ovf6);
        end
        push(5'd21);
        vectors++;
        if (out_valid7 !== 1'b1 || acc7 !== 7'd84 || ovf7 !== 1'b0 || count7 !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL full_acc7: got ov=%b acc=%0d ovf=%b cnt=%0d expected 1/84/0/4", out_valid7, acc7, ovf7, count7);
        end
        vectors++;
        if (out_valid6 !== 1'b1 || acc6 !== 6'd63 || ovf6 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_sat6: got ov=%b acc=%0d ovf=%b expected 1/63/1", out_valid6, acc6, ovf6);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (in_ready7 !== 1'b1 || acc7 !== 7'd0 || ovf6 !== 1'b0 || count7 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL full_drain: got rdy=%b acc=%0d ovf6=%b cnt=%0d expected 1/0/0/0", in_ready7, acc7, ovf6, count7);
        end
    endtask

    task automatic test_hold();
        push(5'd1);
        // Idle cycles in ACCUM must not change the partial sum.
        step(); step();
        vectors++;
        if (acc7 !== 7'd1 || count7 !== 8'd1 || in_ready7 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_accum: got acc=%0d cnt=%0d rdy=%b expected 1/1/1", acc7, count7, in_ready7);
        end
        push(5'd2); push(5'd3); push(5'd4);
        // Offer products during HOLD; none may be taken.
        in_valid = 1'b1; in_product = 5'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (acc7 !== 7'd10 || in_ready7 !== 1'b0 || out_valid7 !== 1'b1 || count7 !== 8'd4) begin
                miscompares++;
                $display("[TB] FAIL hold_%0d: got acc=%0d rdy=%b ov=%b cnt=%0d expected 10/0/1/4", i, acc7, in_ready7, out_valid7, count7);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        vectors++;
        if (in_ready7 !== 1'b1 || out_valid7 !== 1'b0 || acc7 !== 7'd0 || count7 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got rdy=%b ov=%b acc=%0d cnt=%0d expected 1/0/0/0", in_ready7, out_valid7, acc7, count7);
        end
    endtask

    task automatic test_clear();
        push(5'd6); push(5'd9);
        clear = 1'b1; in_valid = 1'b1; in_product = 5'd5;
        step();
        clear = 1'b0; in_valid = 1'b0;
        vectors++;
        if (acc7 !== 7'd0 || count7 !== 8'd0 || in_ready7 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_accum: got acc=%0d cnt=%0d rdy=%b expected 0/0/1", acc7, count7, in_ready7);
        end
        push(5'd1); push(5'd1); push(5'd1); push(5'd1);
        vectors++;
        if (acc7 !== 7'd4 || out_valid7 !== 1'b1 || count7 !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL clear_after: got acc=%0d ov=%b cnt=%0d expected 4/1/4", acc7, out_valid7, count7);
        end
        // Clear beats the handshake while holding a result.
        clear = 1'b1; out_ready = 1'b1;
        step();
        clear = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid7 !== 1'b0 || acc7 !== 7'd0 || count7 !== 8'd0 || in_ready7 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_hold: got ov=%b acc=%0d cnt=%0d rdy=%b expected 0/0/0/1", out_valid7, acc7, count7, in_ready7);
        end
    endtask

    task automatic test_out_of_range();
        push(5'd31); push(5'd31); push(5'd31); push(5'd31);
        vectors++;
        if (acc7 !== 7'd124 || ovf7 !== 1'b0 || acc6 !== 6'd63 || ovf6 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL range31: got acc7=%0d ovf7=%b acc6=%0d ovf6=%b expected 124/0/63/1", acc7, ovf7, acc6, ovf6);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_rst_in_hold();
        push(5'd10); push(5'd10); push(5'd5); push(5'd5);
        vectors++;
        if (acc7 !== 7'd30 || out_valid7 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_pre: got acc=%0d ov=%b expected 30/1", acc7, out_valid7);
        end
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid7 !== 1'b0 || acc7 !== 7'd0 || in_ready7 !== 1'b1 || count7 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_hold: got ov=%b acc=%0d rdy=%b cnt=%0d expected 0/0/1/0", out_valid7, acc7, in_ready7, count7);
        end
    endtask

    task automatic test_random();
        int sum;
        int accepted;
        int cycles;
        int exp7;
        int exp6;
        int waits;
        bit ok;
        ok = 1'b1;
        for (int r = 0; r < 1000 && ok; r++) begin
            sum = 0;
            accepted = 0;
            cycles = 0;
            while (accepted < 4 && ok) begin
                if (in_ready7 !== 1'b1 || out_valid7 !== 1'b0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL rand_ready r%0d: got rdy=%b ov=%b after %0d accepts expected 1/0", r, in_ready7, out_valid7, accepted);
                    ok = 1'b0;
                end else begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_product = 5'($urandom_range(0, 21));
                    step();
                    if (in_valid) begin
                        sum += int'(in_product);
                        accepted++;
                    end
                    cycles++;
                end
            end
            in_valid = 1'b0;
            if (!ok) break;
            exp7 = (sum > 127) ? 127 : sum;
            exp6 = (sum > 63) ? 63 : sum;
            vectors++;
            if (out_valid7 !== 1'b1 || count7 !== 8'd4 || int'(acc7) != exp7 || acc7 === 7'bx) begin
                miscompares++;
                $display("[TB] FAIL rand_acc7 r%0d: got ov=%b cnt=%0d acc=%0d expected 1/4/%0d", r, out_valid7, count7, acc7, exp7);
            end
            vectors++;
            if (int'(acc6) != exp6 || ovf6 !== 1'(sum > 63) || acc6 === 6'bx) begin
                miscompares++;
                $display("[TB] FAIL rand_acc6 r%0d: got acc=%0d ovf=%b expected %0d/%b", r, acc6, ovf6, exp6, sum > 63);
            end
            waits = $urandom_range(0, 2);
            in_valid = 1'b1; in_product = 5'd21;
            for (int w = 0; w < waits; w++) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0; in_valid = 1'b0;
            vectors++;
            if (count7 !== 8'd0 || acc7 !== 7'd0 || in_ready7 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rand_drain r%0d: got cnt=%0d acc=%0d rdy=%b expected 0/0/1", r, count7, acc7, in_ready7);
                ok = 1'b0;
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_inputs();
        test_reset();
        test_full_sum();
        test_hold();
        test_clear();
        test_out_of_range();
        test_rst_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
